pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and memory-wait freezes with a sticky timeout.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned       WAIT_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      INIT,
      RUN,
      MEM_WAIT,
      ERROR
   } state_t;

   state_t            state;
   logic              init_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              hazard;

   assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

   // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      case (state)
         INIT: begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end
         RUN, MEM_WAIT: begin
            if (mem_busy) begin
               pc_en     = 1'b0;
               if_id_en  = 1'b0;
               id_ex_en  = 1'b0;
               ex_mem_en = 1'b0;
               mem_wb_en = 1'b0;
            end else if (ex_branch_taken) begin
               // The flushed ID instruction makes any load-use stall moot.
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (hazard) begin
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
            end
         end
         default: begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= INIT;
         init_cnt    <= 1'b0;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               if (init_cnt) state <= RUN;
               init_cnt <= 1'b1;
            end
            RUN: begin
               if (mem_busy) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (!mem_busy) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LIMIT) begin
                  state       <= ERROR;
                  mem_timeout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            default: mem_timeout <= 1'b1;
         endcase
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic active;
   logic stall_evt;
   logic flush_evt;

   assign active    = (state == RUN) || (state == MEM_WAIT);
   assign stall_evt = active && !pc_en;
   assign flush_evt = active && !mem_busy && ex_branch_taken;

   // Both counters saturate at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_evt && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
         if (flush_evt && (flush_count != '1))  flush_count  <= flush_count + 1'b1;
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=8); counter expectations follow PIPE_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 8;

   // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
   localparam logic [6:0] O_INIT = 7'b0111111;
   localparam logic [6:0] O_NORM = 7'b1111100;
   localparam logic [6:0] O_BR   = 7'b1111111;
   localparam logic [6:0] O_HAZ  = 7'b0011101;
   localparam logic [6:0] O_FRZ  = 7'b0000000;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_busy;
   logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic             if_id_flush, id_ex_flush, mem_timeout;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .mem_busy(mem_busy),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   function automatic logic [6:0] outs();
      return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
   endfunction

   function automatic logic [31:0] exp_cnt(input int n);
`ifdef PIPE_PERF_CNT_EN
      return (n > 255) ? 32'd255 : 32'(n);
`else
      return 32'(n * 0);
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
   endtask

   task automatic load_use_rs2();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #1;
      check("reset_outs", 32'(outs()), 32'(O_INIT));
      cyc();
      cyc();
      check("reset_timeout", 32'(mem_timeout), 32'd0);
      check("reset_stall", 32'(stall_cycles), 32'd0);
      check("reset_flush", 32'(flush_count), 32'd0);

      // Reset release: two INIT cycles, then RUN.
      rst_n = 1'b1;
      #1;
      check("init_cyc1", 32'(outs()), 32'(O_INIT));
      cyc();
      check("init_cyc2", 32'(outs()), 32'(O_INIT));
      cyc();
      check("run_normal", 32'(outs()), 32'(O_NORM));

      // Load-use on rs2 for a single cycle.
      load_use_rs2();
      #1;
      check("haz_rs2", 32'(outs()), 32'(O_HAZ));
      cyc();
      idle();
      #1;
      check("haz_cleared", 32'(outs()), 32'(O_NORM));
      check("stall_after_haz", 32'(stall_cycles), exp_cnt(1));

      // Load-use on rs1, then near-misses that must not stall.
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
      #1;
      check("haz_rs1", 32'(outs()), 32'(O_HAZ));
      cyc();
      id_use_rs1 = 1'b0;
      #1;
      check("no_use_no_haz", 32'(outs()), 32'(O_NORM));
      id_use_rs1 = 1'b1; ex_mem_read = 1'b0;
      #1;
      check("no_load_no_haz", 32'(outs()), 32'(O_NORM));
      cyc();
      check("stall_after_rs1", 32'(stall_cycles), exp_cnt(2));
      idle();

      // Branch together with a hazard: flush wins, no stall.
      load_use_rs2();
      ex_branch_taken = 1'b1;
      #1;
      check("branch_over_haz", 32'(outs()), 32'(O_BR));
      cyc();
      idle();
      #1;
      check("flush_after_br", 32'(flush_count), exp_cnt(1));
      check("stall_after_br", 32'(stall_cycles), exp_cnt(2));

      // mem_busy for 3 cycles with a load to x0: freeze, then normal.
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("busy_frz%0d", i), 32'(outs()), 32'(O_FRZ));
         cyc();
      end
      mem_busy = 1'b0;
      #1;
      check("busy_release", 32'(outs()), 32'(O_NORM));
      cyc();
      check("busy_back_run", 32'(outs()), 32'(O_NORM));
      check("stall_after_busy", 32'(stall_cycles), exp_cnt(5));
      idle();

      // Leaving MEM_WAIT straight into a branch.
      mem_busy = 1'b1;
      cyc();
      mem_busy = 1'b0; ex_branch_taken = 1'b1;
      #1;
      check("wait_to_branch", 32'(outs()), 32'(O_BR));
      cyc();
      ex_branch_taken = 1'b0;
      #1;
      check("flush_after_wait_br", 32'(flush_count), exp_cnt(2));

      // Leaving MEM_WAIT straight into a hazard.
      mem_busy = 1'b1;
      cyc();
      mem_busy = 1'b0;
      load_use_rs2();
      #1;
      check("wait_to_haz", 32'(outs()), 32'(O_HAZ));
      cyc();
      idle();
      #1;
      check("stall_after_wait_haz", 32'(stall_cycles), exp_cnt(8));

      // Timeout: RUN busy cycle + 4 MEM_WAIT cycles, then ERROR.
      mem_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("to_frz%0d", i), 32'(outs()), 32'(O_FRZ));
         check($sformatf("to_flag%0d", i), 32'(mem_timeout), 32'd0);
         cyc();
      end
      check("timeout_set", 32'(mem_timeout), 32'd1);
      check("stall_at_timeout", 32'(stall_cycles), exp_cnt(13));
      mem_busy = 1'b0; ex_branch_taken = 1'b1;
      #1;
      check("error_frz", 32'(outs()), 32'(O_FRZ));
      cyc();
      check("error_sticky", 32'(mem_timeout), 32'd1);
      check("error_no_stall_cnt", 32'(stall_cycles), exp_cnt(13));
      check("error_no_flush_cnt", 32'(flush_count), exp_cnt(2));
      idle();

      // Asynchronous reset out of ERROR.
      rst_n = 1'b0;
      #1;
      check("err_rst_timeout", 32'(mem_timeout), 32'd0);
      check("err_rst_outs", 32'(outs()), 32'(O_INIT));
      check("err_rst_stall", 32'(stall_cycles), 32'd0);
      cyc();
      rst_n = 1'b1;
      #1;
      check("reinit1", 32'(outs()), 32'(O_INIT));
      cyc();
      check("reinit2", 32'(outs()), 32'(O_INIT));
      cyc();
      check("rerun", 32'(outs()), 32'(O_NORM));

      // Held hazard for 300 cycles: the 8-bit stall counter saturates.
      load_use_rs2();
      for (int i = 0; i < 300; i++) cyc();
      check("stall_saturate", 32'(stall_cycles), exp_cnt(300));
      check("still_haz", 32'(outs()), 32'(O_HAZ));
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
